// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch
// Fetches one 16-bit word per PC over a req/ack handshake into an IR and
// steers the program counter (increment after a good fetch, load on flush).
// Revision: 1.0
// ============================================================================
module instruction_fetch #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] pc_in,
  output logic        pc_enable,
  output logic        pc_select,
  input  logic        flush,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] ir_out,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             flush_pend;
  logic             flush_act;
  logic             fetch_good;

  // Flush owns the PC strobe; a good fetch only increments when no flush is live.
  assign flush_act  = flush && (state != S_ERR);
  assign fetch_good = (state == S_WAIT) && mem_ack && !flush_pend && !flush;
  assign pc_select  = flush_act;
  assign pc_enable  = flush_act || fetch_good;
  assign mem_req    = (state == S_WAIT);
  assign ir_valid   = (state == S_HOLD);
  assign fetch_err  = (state == S_ERR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      mem_addr   <= '0;
      ir_out     <= '0;
      wait_cnt   <= '0;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!flush && run) state <= S_ISSUE;
        end
        S_ISSUE: begin
          // On flush stay here so the reloaded PC is sampled next cycle.
          if (!flush) begin
            mem_addr <= pc_in;
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            flush_pend <= 1'b0;
            if (flush_pend || flush) begin
              state <= S_ISSUE;
            end else begin
              ir_out <= mem_rdata;
              state  <= S_HOLD;
            end
          end else begin
            if (flush) flush_pend <= 1'b1;
            if (wait_cnt == CNT_LAST) state <= S_ERR;
            else wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (flush) state <= S_ISSUE;
          else if (ir_ready) state <= run ? S_ISSUE : S_IDLE;
        end
        S_ERR:   state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_instruction_fetch
// Directed and randomized self-checking bench for instruction_fetch.
// Revision: 1.0
// ============================================================================
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] pc_in;
  logic        pc_enable;
  logic        pc_select;
  logic        flush;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic        ir_ready;
  logic        fetch_err;

  int          checks = 0;
  int          errors = 0;

  // Bench plays the program counter: bus value and the strobe seen last cycle.
  logic [15:0] bus;
  logic        cap_en;
  logic        cap_sel;
  logic [15:0] cap_bus;

  instruction_fetch #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .pc_in     (pc_in),
    .pc_enable (pc_enable),
    .pc_select (pc_select),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir_out    (ir_out),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C96;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic begin_cycle();
    @(negedge clk);
    if (cap_en) pc_in = cap_sel ? cap_bus : pc_in + 16'd1;
    cap_en = 1'b0;
  endtask

  task automatic end_drive();
    #1;
    cap_en  = pc_enable;
    cap_sel = pc_select;
    cap_bus = bus;
  endtask

  initial begin
    logic [15:0] addr_q[$];
    int          delivered;
    int          wait_left;
    logic [15:0] exp_next;

    rst = 1'b0; run = 1'b0; pc_in = '0; flush = 1'b0; mem_ack = 1'b0;
    mem_rdata = '0; ir_ready = 1'b0; bus = '0;
    cap_en = 1'b0; cap_sel = 1'b0; cap_bus = '0;

    // Reset state
    begin_cycle(); end_drive();
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_ir", ir_out, 0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_pcen", pc_enable, 0);

    // Single fetch, ack on the third request cycle
    begin_cycle(); rst = 1'b1; run = 1'b1; pc_in = 16'h0010; end_drive();
    begin_cycle(); end_drive();
    chk("t2_issue_req", mem_req, 0);
    begin_cycle(); end_drive();
    chk("t2_req", mem_req, 1);
    chk("t2_addr", mem_addr, 16'h0010);
    begin_cycle(); end_drive();
    chk("t2_req_hold", mem_req, 1);
    begin_cycle(); mem_ack = 1'b1; mem_rdata = 16'hA5A5; end_drive();
    chk("t2_pcen", pc_enable, 1);
    chk("t2_pcsel", pc_select, 0);
    begin_cycle(); mem_ack = 1'b0; mem_rdata = 16'h1234; end_drive();
    chk("t2_ir", ir_out, 16'hA5A5);
    chk("t2_valid", ir_valid, 1);
    chk("t2_req_low", mem_req, 0);
    chk("t2_pcen_once", pc_enable, 0);
    begin_cycle(); ir_ready = 1'b1; end_drive();
    chk("t2_valid_wait", ir_valid, 1);
    begin_cycle(); ir_ready = 1'b0; end_drive();
    chk("t2_valid_drop", ir_valid, 0);

    // Asynchronous reset while waiting for memory
    begin_cycle(); end_drive();
    chk("t1_req", mem_req, 1);
    chk("t1_addr", mem_addr, 16'h0011);
    #2 rst = 1'b0;
    #1;
    chk("t1_async_req", mem_req, 0);
    chk("t1_async_addr", mem_addr, 0);
    chk("t1_async_ir", ir_out, 0);
    cap_en = 1'b0;

    // Zero-wait streaming from PC 0
    begin_cycle(); rst = 1'b1; run = 1'b1; pc_in = 16'h0000; end_drive();
    delivered = 0;
    for (int i = 0; i < 12; i++) begin
      begin_cycle();
      ir_ready  = 1'b1;
      mem_ack   = mem_req;
      mem_rdata = mem_word(mem_addr);
      end_drive();
      if (mem_ack) addr_q.push_back(mem_addr);
      if (ir_valid && ir_ready) begin
        chk("t3_ir", ir_out, mem_word(16'(delivered)));
        delivered++;
      end
    end
    chk("t3_count", 16'(delivered), 4);
    chk("t3_nreq", 16'(addr_q.size()), 4);
    for (int i = 0; i < addr_q.size(); i++) chk("t3_addr", addr_q[i], 16'(i));

    // Flush during WAIT
    begin_cycle(); mem_ack = 1'b0; ir_ready = 1'b0; end_drive();
    chk("t4_issue_req", mem_req, 0);
    begin_cycle(); flush = 1'b1; bus = 16'h0200; end_drive();
    chk("t4_req", mem_req, 1);
    chk("t4_addr_old", mem_addr, 16'h0004);
    chk("t4_flush_en", pc_enable, 1);
    chk("t4_flush_sel", pc_select, 1);
    begin_cycle(); flush = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hDEAD; end_drive();
    chk("t4_drop_pcen", pc_enable, 0);
    begin_cycle(); mem_ack = 1'b0; end_drive();
    chk("t4_drop_valid", ir_valid, 0);
    chk("t4_reissue_req", mem_req, 0);
    begin_cycle(); mem_ack = 1'b1; mem_rdata = mem_word(16'h0200); end_drive();
    chk("t4_new_addr", mem_addr, 16'h0200);
    chk("t4_new_pcen", pc_enable, 1);
    chk("t4_new_sel", pc_select, 0);

    // Flush and ir_ready together in HOLD
    begin_cycle(); mem_ack = 1'b0; ir_ready = 1'b1; flush = 1'b1; bus = 16'h0300; end_drive();
    chk("t5_ir", ir_out, mem_word(16'h0200));
    chk("t5_valid", ir_valid, 1);
    chk("t5_pcen", pc_enable, 1);
    chk("t5_sel", pc_select, 1);
    begin_cycle(); flush = 1'b0; ir_ready = 1'b0; end_drive();
    chk("t5_valid_fall", ir_valid, 0);
    begin_cycle(); end_drive();
    chk("t5_refetch_req", mem_req, 1);
    chk("t5_refetch_addr", mem_addr, 16'h0300);

    // Timeout: 16 request cycles without ack, then sticky error
    for (int i = 1; i < 16; i++) begin
      begin_cycle(); end_drive();
      chk("t6_waiting", {mem_req, fetch_err}, 16'b10);
    end
    begin_cycle(); flush = 1'b1; end_drive();
    chk("t6_err", fetch_err, 1);
    chk("t6_req", mem_req, 0);
    chk("t6_valid", ir_valid, 0);
    chk("t6_no_pcen", pc_enable, 0);
    for (int i = 0; i < 3; i++) begin
      begin_cycle(); flush = 1'b0; mem_ack = 1'(i); end_drive();
      chk("t6_sticky", fetch_err, 1);
    end
    begin_cycle(); mem_ack = 1'b0;
    #2 rst = 1'b0;
    #1 chk("t6_reset_clear", fetch_err, 0);
    cap_en = 1'b0;

    // Randomized run against an address-sequence model
    begin_cycle(); rst = 1'b1; run = 1'b1; pc_in = 16'($urandom); end_drive();
    exp_next  = pc_in;
    wait_left = $urandom_range(0, 4);
    delivered = 0;
    for (int i = 0; i < 4000; i++) begin
      begin_cycle();
      flush    = ($urandom_range(0, 15) == 0);
      bus      = 16'($urandom);
      ir_ready = 1'($urandom_range(0, 1));
      mem_ack  = 1'b0;
      mem_rdata = 16'($urandom);
      if (mem_req) begin
        if (wait_left == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          wait_left = $urandom_range(0, 4);
        end else begin
          wait_left--;
        end
      end
      end_drive();
      if (flush) begin
        chk("rnd_flush", {pc_enable, pc_select}, 16'b11);
        exp_next = bus;
      end else if (ir_valid && ir_ready) begin
        chk("rnd_ir", ir_out, mem_word(exp_next));
        exp_next = exp_next + 16'd1;
        delivered++;
      end
    end
    chk("rnd_progress", 16'(delivered > 100), 1);
    chk("rnd_no_err", fetch_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
